// File: rtl/fir_result_reader.sv
// FIR result capture: aligns i_ce with pipeline latency, rescales/saturates, buffers in a FWFT FIFO.
// Optional macro FIR_READER_SATCNT_EN adds o_sat_count, a 16-bit count of clipped samples.
module fir_result_reader #(
  parameter int RESULT_W   = 31,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 12,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_ce,
  input  logic signed [RESULT_W-1:0]    i_result,
  output logic signed [OUT_W-1:0]       o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow,
  input  logic                          i_clear_ovf
`ifdef FIR_READER_SATCNT_EN
  ,
  output logic [15:0]                   o_sat_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [RESULT_W:0] HALF    = (RESULT_W+1)'(64'd1 << (SHIFT-1));
  localparam logic signed [RESULT_W:0] SAT_MAX = {{(RESULT_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RESULT_W:0] SAT_MIN = {{(RESULT_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic signed [RESULT_W:0] round_shift(input logic signed [RESULT_W-1:0] x);
    logic signed [RESULT_W:0] ext;
    ext = $signed({x[RESULT_W-1], x}) + HALF;
    return ext >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [RESULT_W:0] r);
    if (r > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (r < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  function automatic logic is_clip(input logic signed [RESULT_W:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  logic [LATENCY-1:0]       ce_dly_q, ce_dly_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic signed [OUT_W-1:0]  hold_q, hold_d;
  logic signed [OUT_W-1:0]  mem_q [FIFO_DEPTH];

  logic signed [RESULT_W:0] scaled_p0;
  logic signed [OUT_W-1:0]  sample_p0;
  logic                     cap_p0, full, pop, push, drop;

`ifdef FIR_READER_SATCNT_EN
  logic        clip_p0;
  logic [15:0] sat_cnt_q, sat_cnt_d;
`endif

  // Stage 0: capture decision, rescale, FIFO bookkeeping
  always_comb begin
    cap_p0    = ce_dly_q[LATENCY-1];
    scaled_p0 = round_shift(i_result);
    sample_p0 = saturate(scaled_p0);
    full      = (count_q == CW'(FIFO_DEPTH));
    pop       = (count_q != '0) && i_ready;
    push      = cap_p0 && (!full || pop);
    drop      = cap_p0 && full && !pop;

    ce_dly_d    = ce_dly_q << 1;
    ce_dly_d[0] = i_ce;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    hold_d      = pop ? mem_q[rd_ptr_q] : hold_q;
    ovf_d       = drop | (ovf_q & ~i_clear_ovf);
  end

`ifdef FIR_READER_SATCNT_EN
  always_comb begin
    clip_p0   = push && is_clip(scaled_p0);
    sat_cnt_d = sat_cnt_q;
    if (i_clear_ovf)
      sat_cnt_d = {15'd0, clip_p0};
    else if (clip_p0 && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) sat_cnt_q <= '0;
    else         sat_cnt_q <= sat_cnt_d;
  end

  assign o_sat_count = sat_cnt_q;
`endif

  // Stage 1: registered FIFO state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ce_dly_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      ce_dly_q <= ce_dly_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_p0;
  end

  // Empty FIFO shows the most recently popped word.
  assign o_valid    = (count_q != '0);
  assign o_data     = o_valid ? mem_q[rd_ptr_q] : hold_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule
